// File: rtl/gpio_pkg.sv
// Shared register offsets, address window bases and select decoding for the GPIO responder.
// The switch debounce filter is built only when SWITCH_DEBOUNCE_EN is defined.
package gpio_pkg;

  localparam logic [3:0] LED_LO  = 4'h0;
  localparam logic [3:0] LED_HI  = 4'h2;
  localparam logic [3:0] SW_LO   = 4'h0;
  localparam logic [3:0] SW_HI   = 4'h2;
  localparam logic [3:0] SW_STAT = 4'h4;

  localparam logic [27:0] LED_BASE = 28'hFFFFFC6;
  localparam logic [27:0] SW_BASE  = 28'hFFFFFC7;

  typedef enum logic [1:0] {
    SEL_NONE     = 2'b00,
    SEL_LED      = 2'b01,
    SEL_SW       = 2'b10,
    SEL_CONFLICT = 2'b11
  } sel_e;

  // Both chip selects at once is a decode fault upstream: treated as no access.
  function automatic sel_e decode_sel(input logic ledctrl, input logic switchctrl);
    return sel_e'({switchctrl, ledctrl});
  endfunction

  function automatic logic led_window_hit(input logic [31:0] caddress);
    return caddress[31:4] == LED_BASE;
  endfunction

  function automatic logic sw_window_hit(input logic [31:0] caddress);
    return caddress[31:4] == SW_BASE;
  endfunction

endpackage

// File: rtl/gpio_responder_switch_debounce.sv
// Two-flop synchronizer plus optional shared-counter debounce for the board switches.
// SWITCH_DEBOUNCE_EN selects the filtered path; otherwise the synchronized value is registered directly.
module switch_debounce
  import gpio_pkg::*;
#(
  parameter int          WIDTH           = 24,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable_out,
  output logic             commit
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;

`ifdef SWITCH_DEBOUNCE_EN
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [19:0]      cnt_q, cnt_d;

  // Any movement of the synchronized vector restarts the shared count; the new value
  // is accepted on the edge where the count reaches DEBOUNCE_CYCLES.
  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != DEBOUNCE_CYCLES) cnt_d = cnt_q + 20'd1;
      if ((cnt_d == DEBOUNCE_CYCLES) && (cand_q != stable_q)) stable_d = cand_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
`else
  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    stable_d = sync2_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
    end
  end
`endif

  assign stable_out = stable_q;
  assign commit     = !reset && (stable_d != stable_q);

endmodule

// File: rtl/gpio_responder.sv
// Memory-mapped LED/switch responder: 24-bit LED register, debounced switch readback, sticky change flag.
// Build with SWITCH_DEBOUNCE_EN to enable switch debouncing (see switch_debounce).
module gpio_responder
  import gpio_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [23:0] LED_RESET       = 24'h000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ledctrl,
  input  logic        switchctrl,
  input  logic        ioread,
  input  logic        iowrite,
  input  logic [3:0]  address,
  input  logic [15:0] write_data,
  output logic [15:0] ioread_data,
  input  logic [23:0] switch_in,
  output logic [23:0] led_out,
  output logic        sw_changed
);

  sel_e        sel;
  logic [23:0] led_q, led_d;
  logic        changed_q, changed_d;
  logic [23:0] sw_stable;
  logic        sw_commit;

  assign sel = decode_sel(ledctrl, switchctrl);

  switch_debounce #(
    .WIDTH          (24),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_switch_debounce (
    .clock     (clock),
    .reset     (reset),
    .raw_in    (switch_in),
    .stable_out(sw_stable),
    .commit    (sw_commit)
  );

  // A fresh switch commit outranks a simultaneous write-1-to-clear of the flag.
  always_comb begin
    led_d     = led_q;
    changed_d = changed_q;
    if (iowrite && (sel == SEL_LED)) begin
      case (address)
        LED_LO:  led_d[15:0]  = write_data;
        LED_HI:  led_d[23:16] = write_data[7:0];
        default: ;
      endcase
    end
    if (iowrite && (sel == SEL_SW) && (address == SW_STAT) && write_data[0]) changed_d = 1'b0;
    if (sw_commit) changed_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q     <= LED_RESET;
      changed_q <= 1'b0;
    end else begin
      led_q     <= led_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    ioread_data = 16'h0000;
    if (ioread && (sel == SEL_LED)) begin
      case (address)
        LED_LO:  ioread_data = led_q[15:0];
        LED_HI:  ioread_data = {8'h00, led_q[23:16]};
        default: ioread_data = 16'h0000;
      endcase
    end else if (ioread && (sel == SEL_SW) && !reset) begin
      case (address)
        SW_LO:   ioread_data = sw_stable[15:0];
        SW_HI:   ioread_data = {8'h00, sw_stable[23:16]};
        SW_STAT: ioread_data = {15'h0000, changed_q};
        default: ioread_data = 16'h0000;
      endcase
    end
  end

  assign led_out    = led_q;
  assign sw_changed = changed_q;

endmodule

// File: tb/tb_gpio_responder.sv
// Self-checking bench for gpio_responder: directed register-map steps followed by randomized traffic,
// compared every cycle against a behavioural model. Honours SWITCH_DEBOUNCE_EN like the design.
module tb_gpio_responder;

  localparam logic [19:0] DEB  = 20'd8;
  localparam logic [23:0] LRST = 24'h000000;
  localparam int          WIN  = 9;

  logic        clock = 1'b0;
  logic        reset;
  logic        ledctrl, switchctrl, ioread, iowrite;
  logic [3:0]  address;
  logic [15:0] write_data;
  logic [15:0] ioread_data;
  logic [23:0] switch_in;
  logic [23:0] led_out;
  logic        sw_changed;

  int checks = 0;
  int errors = 0;

  logic [23:0] m_led;
  logic [23:0] m_pipe1, m_pipe2;
  logic [23:0] m_stable;
  logic        m_changed;
  logic [23:0] m_hist[$];

  gpio_responder #(
    .DEBOUNCE_CYCLES(DEB),
    .LED_RESET      (LRST)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ledctrl    (ledctrl),
    .switchctrl (switchctrl),
    .ioread     (ioread),
    .iowrite    (iowrite),
    .address    (address),
    .write_data (write_data),
    .ioread_data(ioread_data),
    .switch_in  (switch_in),
    .led_out    (led_out),
    .sw_changed (sw_changed)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] model_read();
    logic [15:0] r;
    r = 16'h0000;
    if (ioread && ledctrl && !switchctrl) begin
      if (address == 4'h0) r = m_led[15:0];
      else if (address == 4'h2) r = {8'h00, m_led[23:16]};
    end else if (ioread && switchctrl && !ledctrl && !reset) begin
      if (address == 4'h0) r = m_stable[15:0];
      else if (address == 4'h2) r = {8'h00, m_stable[23:16]};
      else if (address == 4'h4) r = {15'h0000, m_changed};
    end
    return r;
  endfunction

  // Advances the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [23:0] synced;
    logic [23:0] next_stable;
    logic        all_same;
    if (reset) begin
      m_led     = LRST;
      m_pipe1   = '0;
      m_pipe2   = '0;
      m_stable  = '0;
      m_changed = 1'b0;
      m_hist    = {24'h0};
      return;
    end
    synced  = m_pipe2;
    m_pipe2 = m_pipe1;
    m_pipe1 = switch_in;
    m_hist.push_back(synced);
    if (m_hist.size() > WIN) void'(m_hist.pop_front());
`ifdef SWITCH_DEBOUNCE_EN
    next_stable = m_stable;
    all_same = (m_hist.size() == WIN);
    foreach (m_hist[i]) if (m_hist[i] != synced) all_same = 1'b0;
    if (all_same) next_stable = synced;
`else
    all_same = 1'b1;
    next_stable = synced;
`endif
    if (iowrite && ledctrl && !switchctrl) begin
      if (address == 4'h0) m_led[15:0] = write_data;
      else if (address == 4'h2) m_led[23:16] = write_data[7:0];
    end
    if (iowrite && switchctrl && !ledctrl && address == 4'h4 && write_data[0]) m_changed = 1'b0;
    if (next_stable != m_stable) m_changed = 1'b1;
    m_stable = next_stable;
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    checkOutput("led_out", led_out, m_led);
    checkOutput("ioread_data", {8'h00, ioread_data}, {8'h00, model_read()});
    checkOutput("sw_changed", {23'h0, sw_changed}, {23'h0, m_changed});
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    ledctrl = 0; switchctrl = 0; ioread = 0; iowrite = 0;
    address = 4'h0; write_data = 16'h0000;
  endtask

  task automatic applyStimulus(input logic ls, input logic ss, input logic rd, input logic wr,
                               input logic [3:0] a, input logic [15:0] d);
    ledctrl = ls; switchctrl = ss; ioread = rd; iowrite = wr; address = a; write_data = d;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    switch_in = 24'hFEDCBA;
    m_hist = {24'h0};
    @(negedge clock);
    applyStimulus(0, 1, 1, 0, 4'h0, 16'h0);
    tick();
    tick();
    checkOutput("reset_led", led_out, LRST);
    checkOutput("reset_sw_read", {8'h00, ioread_data}, 24'h0);
    checkOutput("reset_flag", {23'h0, sw_changed}, 24'h0);

    reset = 1'b0;
    switch_in = 24'h000000;
    idle();
    for (int i = 0; i < 4; i++) tick();

    applyStimulus(1, 0, 0, 1, 4'h0, 16'hA5A5);
    tick();
    idle();
    checkOutput("led_write_lo", led_out, 24'h00A5A5);
    applyStimulus(1, 0, 1, 0, 4'h0, 16'h0);
    #1;
    checkOutput("led_read_lo", {8'h00, ioread_data}, 24'h00A5A5);

    applyStimulus(1, 0, 0, 1, 4'h2, 16'hFF3C);
    tick();
    idle();
    checkOutput("led_write_hi", led_out, 24'h3CA5A5);
    applyStimulus(1, 0, 1, 0, 4'h2, 16'h0);
    #1;
    checkOutput("led_read_hi", {8'h00, ioread_data}, 24'h00003C);
    idle();

    switch_in = 24'h123456;
    for (int i = 0; i < 11; i++) tick();
    applyStimulus(0, 1, 1, 0, 4'h0, 16'h0);
    #1;
    checkOutput("sw_read_lo", {8'h00, ioread_data}, 24'h003456);
    applyStimulus(0, 1, 1, 0, 4'h2, 16'h0);
    #1;
    checkOutput("sw_read_hi", {8'h00, ioread_data}, 24'h000012);
    checkOutput("sw_flag_set", {23'h0, sw_changed}, 24'h1);
    applyStimulus(0, 1, 0, 1, 4'h4, 16'h0001);
    tick();
    idle();
    checkOutput("sw_flag_clear", {23'h0, sw_changed}, 24'h0);

    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) switch_in[0] = ~switch_in[0];
      tick();
    end
`ifdef SWITCH_DEBOUNCE_EN
    checkOutput("bounce_flag", {23'h0, sw_changed}, 24'h0);
    checkOutput("bounce_stable", dut.sw_stable, 24'h123456);
`else
    checkOutput("nofilter_flag", {23'h0, sw_changed}, 24'h1);
`endif
    switch_in = 24'h123456;
    for (int i = 0; i < 12; i++) tick();
    applyStimulus(0, 1, 0, 1, 4'h4, 16'h0001);
    tick();
    idle();

    // Hold a clear write every cycle so one of them lands on the commit edge.
    switch_in = 24'hABCDEF;
    applyStimulus(0, 1, 0, 1, 4'h4, 16'h0001);
    for (int i = 0; i < 40 && !m_changed; i++) tick();
    idle();
    tick();
    checkOutput("set_wins", {23'h0, sw_changed}, 24'h1);
    applyStimulus(0, 1, 0, 1, 4'h4, 16'h0001);
    tick();
    idle();
    checkOutput("clear_after_set", {23'h0, sw_changed}, 24'h0);

    applyStimulus(1, 1, 1, 1, 4'h0, 16'h1234);
    #1;
    checkOutput("conflict_read", {8'h00, ioread_data}, 24'h0);
    tick();
    idle();
    checkOutput("conflict_led", led_out, 24'h3CA5A5);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] addr_pick;
      reset = ($urandom_range(0, 79) == 0);
      case ($urandom_range(0, 3))
        0: addr_pick = 4'h0;
        1: addr_pick = 4'h2;
        2: addr_pick = 4'h4;
        default: addr_pick = 4'($urandom);
      endcase
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                    addr_pick, 16'($urandom));
      if ($urandom_range(0, 13) == 0) begin
        if ($urandom_range(0, 1) == 0) switch_in = 24'($urandom);
        else switch_in[$urandom_range(0, 23)] ^= 1'b1;
      end
      tick();
    end
    reset = 1'b0;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_responder.md
GPIO_RESPONDER -- requirements
Module: gpio_responder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20'd500000, giving the consecutive stable cycles needed to accept a switch change.
REQ-002 The block SHALL have parameter LED_RESET, default 24'h000000, giving the LED register value after reset.
REQ-003 The block SHALL have port clock, input, 1 bit: the single CPU clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ledctrl, input, 1 bit: LED chip select (address window 0xFFFFFC60-6F).
REQ-006 The block SHALL have port switchctrl, input, 1 bit: switch chip select (address window 0xFFFFFC70-7F).
REQ-007 The block SHALL have ports ioread and iowrite, input, 1 bit each: CPU IO read and write strobes.
REQ-008 The block SHALL have port address, input, 4 bits: byte offset within the selected window, taken from caddress[3:0].
REQ-009 The block SHALL have port write_data, input, 16 bits: CPU write data, taken from the lower half of the bus.
REQ-010 The block SHALL have port ioread_data, output, 16 bits: read data returned to the CPU.
REQ-011 The block SHALL have port switch_in, input, 24 bits: raw asynchronous board switches.
REQ-012 The block SHALL have port led_out, output, 24 bits: board LEDs.
REQ-013 The block SHALL have port sw_changed, output, 1 bit: sticky switch-change flag.

Function
REQ-014 LED register map: offset 0x0 is LED[15:0] (RW); offset 0x2 is LED[23:16] in bits [7:0], with bits [15:8] reading 0 and ignored on write.
REQ-015 Switch register map: offset 0x0 is SW[15:0] (RO); offset 0x2 is SW[23:16] in bits [7:0]; offset 0x4 is status, with bit0 = sw_changed and write-1-to-clear.
REQ-016 A write SHALL occur only when iowrite=1 and its select is 1, and SHALL take effect at the next rising clock edge; led_out reflects it one cycle after the write cycle.
REQ-017 ioread_data SHALL be combinational from registered state, valid in the same cycle that ioread=1 with a select, and 16'h0000 otherwise.
REQ-018 Unmapped offsets SHALL read 0; writes to them SHALL be ignored; writes to SW offsets 0x0 and 0x2 SHALL be ignored.
REQ-019 If ledctrl and switchctrl are both 1, ioread_data SHALL be 0 and no register SHALL be written.
REQ-020 switch_in SHALL pass through a two-flop synchronizer before any use.
REQ-021 Debounce: the synchronized vector is compared with a candidate register; any difference loads the candidate and clears a shared counter; otherwise the counter increments, saturating at DEBOUNCE_CYCLES.
REQ-022 When the counter reaches DEBOUNCE_CYCLES and the candidate differs from the stable register, the stable register SHALL load the candidate on that edge.
REQ-023 sw_changed SHALL set on the edge where the stable register changes value.
REQ-024 If a set (REQ-023) and a write-1-to-clear occur on the same edge, set SHALL win.
REQ-025 A switch bounce (any change) during counting SHALL restart the count from 0, with no partial acceptance.

Reset
REQ-026 On reset=1 at a clock edge: led_out=LED_RESET, synchronizer/candidate/stable registers=24'h0, counter=0, sw_changed=0.
REQ-027 Reset during a debounce SHALL discard the pending change; ioread_data SHALL read 0 for SW during reset.

Configuration
REQ-028 With SWITCH_DEBOUNCE_EN defined: behaviour per REQ-021 to REQ-025.
REQ-029 Without SWITCH_DEBOUNCE_EN: the stable register SHALL load the synchronized vector every cycle (2-cycle latency), no counter SHALL be built, and sw_changed SHALL set on any stable change.

Structure
REQ-030 Shared package gpio_pkg SHALL hold the offset constants (LED_LO=4'h0, LED_HI=4'h2, SW_LO=4'h0, SW_HI=4'h2, SW_STAT=4'h4) and the window bases 28'hFFFFFC6 and 28'hFFFFFC7.
REQ-031 The synchronizer plus debounce logic SHALL be one sub-module, switch_debounce (24-bit, parameterised).

Verification
REQ-032 Reset, then write 16'hA5A5 to LED 0x0 with ledctrl=1 and iowrite=1 -> led_out=24'h00A5A5 on the next cycle; reading 0x0 returns 16'hA5A5.
REQ-033 Write 16'hFF3C to LED 0x2 -> led_out[23:16]=8'h3C; reading 0x2 returns 16'h003C.
REQ-034 With DEBOUNCE_CYCLES=8, hold switch_in=24'h123456 -> SW 0x0 reads 16'h3456 and 0x2 reads 16'h0012 after 2+8+1 cycles; sw_changed=1.
REQ-035 Toggle switch_in bit0 every 5 cycles (DEBOUNCE_CYCLES=8) -> the stable value never changes and sw_changed stays 0.
REQ-036 Write 16'h0001 to SW 0x4 on the same edge a new stable value commits -> sw_changed=1; a later clear-only write -> 0.
REQ-037 With ledctrl=1 and switchctrl=1 together plus a write -> led_out unchanged and ioread_data=0.
